// File: rtl/novacore_oci_dct_pkg.sv
// Shared constants and state encoding for the OCI DCT trace packer.
// Used by the packer top and its output holding register.
package novacore_oci_dct_pkg;

   localparam int SYM_W   = 2;
   localparam int NUM_SYM = 15;
   localparam int BUF_W   = SYM_W * NUM_SYM;
   localparam int CNT_W   = 4;

   typedef enum logic [1:0] {
      DCT_RUN   = 2'd0,
      DCT_DRAIN = 2'd1,
      DCT_ENDED = 2'd2
   } dct_state_e;

endpackage

// File: rtl/novacore_oci_dct_outreg.sv
// Valid/ready holding register for packed DCT words. A load always wins over
// a transfer; after a plain transfer the word and count stay visible with valid low.
module novacore_oci_dct_outreg
   import novacore_oci_dct_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_load,
   input  logic [BUF_W-1:0] i_buf,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic             i_ready,
   output logic             o_free,
   output logic             o_transfer,
   output logic             o_valid,
   output logic [BUF_W-1:0] o_buf,
   output logic [CNT_W-1:0] o_cnt
);

   logic             r_valid;
   logic [BUF_W-1:0] r_buf;
   logic [CNT_W-1:0] r_cnt;

   assign o_free     = ~r_valid | i_ready;
   assign o_transfer = r_valid & i_ready;
   assign o_valid    = r_valid;
   assign o_buf      = r_buf;
   assign o_cnt      = r_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid <= 1'b0;
         r_buf   <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_buf   <= i_buf;
         r_cnt   <= i_cnt;
      end else if (o_transfer) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/novacore_nios2_gen2_cpu_oci_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit DCT words and sequences end-of-test drain.
// Optional feature: define NOVACORE_DCT_OVF_CNT_EN to build the saturating drop counter.
//
// state     | meaning
// DCT_RUN   | accepting symbols, words handed off when full or flushed
// DCT_DRAIN | symbols ignored, partial word forced out, waiting for consumer
// DCT_ENDED | drain complete, test_has_ended high, everything frozen
module novacoreblaster_nios2_gen2_cpu_oci_dct_packer
   import novacore_oci_dct_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_sym_valid,
   input  logic [SYM_W-1:0] i_sym_data,
   input  logic             i_flush,
   input  logic             i_test_ending,
   output logic [BUF_W-1:0] o_dct_buffer,
   output logic [CNT_W-1:0] o_dct_count,
   output logic             o_dct_valid,
   input  logic             i_dct_ready,
   output logic             o_test_has_ended,
   output logic             o_overflow,
   output logic [15:0]      o_ovf_count
);

   dct_state_e       r_state, w_state_nxt;
   logic [BUF_W-1:0] r_acc_buf, w_acc_buf_nxt;
   logic [CNT_W-1:0] r_acc_cnt, w_acc_cnt_nxt;
   logic             r_flush_pending, w_flush_nxt;
   logic             r_overflow;

   logic             w_out_free, w_transfer;
   logic             w_accept, w_acc_full, w_acc_empty, w_flush_eff;
   logic             w_handoff, w_drop, w_store;
   logic [CNT_W-1:0] w_idx;

   assign w_accept    = (r_state == DCT_RUN) & i_sym_valid;
   assign w_acc_full  = (r_acc_cnt == CNT_W'(NUM_SYM));
   assign w_acc_empty = (r_acc_cnt == '0);
   assign w_flush_eff = r_flush_pending | (r_state == DCT_DRAIN);
   assign w_handoff   = (r_state != DCT_ENDED) & w_out_free &
                        (w_acc_full | (w_flush_eff & ~w_acc_empty));
   assign w_drop      = w_accept & w_acc_full & ~w_handoff;
   assign w_store     = w_accept & (w_handoff | ~w_acc_full);
   assign w_idx       = w_handoff ? '0 : r_acc_cnt;

   // a flush against an empty accumulator is dropped rather than parked
   assign w_flush_nxt = ~w_acc_empty &
                        ((i_flush & (r_state == DCT_RUN)) | (r_flush_pending & ~w_handoff));

   always_comb begin
      w_acc_buf_nxt = w_handoff ? '0 : r_acc_buf;
      w_acc_cnt_nxt = w_idx;
      if (w_store) begin
         for (int k = 0; k < NUM_SYM; k++) begin
            if (CNT_W'(k) == w_idx) w_acc_buf_nxt[k*SYM_W +: SYM_W] = i_sym_data;
         end
         w_acc_cnt_nxt = w_idx + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DCT_RUN:   if (i_test_ending) w_state_nxt = DCT_DRAIN;
         DCT_DRAIN: if (w_acc_empty & (~o_dct_valid | w_transfer)) w_state_nxt = DCT_ENDED;
         default:   w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state         <= DCT_RUN;
         r_acc_buf       <= '0;
         r_acc_cnt       <= '0;
         r_flush_pending <= 1'b0;
         r_overflow      <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_acc_buf       <= w_acc_buf_nxt;
         r_acc_cnt       <= w_acc_cnt_nxt;
         r_flush_pending <= w_flush_nxt;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

`ifdef NOVACORE_DCT_OVF_CNT_EN
   logic [15:0] r_ovf_count;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)
         r_ovf_count <= '0;
      else if (w_drop && (r_ovf_count != 16'hFFFF))
         r_ovf_count <= r_ovf_count + 16'd1;
   end

   assign o_ovf_count = r_ovf_count;
`else
   assign o_ovf_count = '0;
`endif

   novacore_oci_dct_outreg u_outreg (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (w_handoff),
      .i_buf      (r_acc_buf),
      .i_cnt      (r_acc_cnt),
      .i_ready    (i_dct_ready),
      .o_free     (w_out_free),
      .o_transfer (w_transfer),
      .o_valid    (o_dct_valid),
      .o_buf      (o_dct_buffer),
      .o_cnt      (o_dct_count)
   );

   assign o_test_has_ended = (r_state == DCT_ENDED);
   assign o_overflow       = r_overflow;

endmodule
